// File: rtl/lif_stdp_pkg.sv
// Shared types and arithmetic helpers for the LIF/STDP neuron.
// Helpers work on 32-bit words; callers zero-extend and truncate to their widths.
package lif_stdp_pkg;

  localparam int unsigned W_WIDTH_DEF     = 8;
  localparam int unsigned TRACE_WIDTH_DEF = 6;

  typedef logic [W_WIDTH_DEF-1:0]     weight_t;
  typedef logic [TRACE_WIDTH_DEF-1:0] trace_t;
  typedef logic [31:0]                word_t;

  // a + b, clamped to max_v
  function automatic word_t sat_add(input word_t a, input word_t b, input word_t max_v);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max_v}) ? max_v : s[31:0];
  endfunction

  // a - b, floored at zero
  function automatic word_t sat_sub(input word_t a, input word_t b);
    return (b > a) ? '0 : (a - b);
  endfunction

  // t - max(t >> shift, 1), floored at zero
  function automatic word_t trace_decay(input word_t t, input int unsigned shift);
    word_t d;
    d = t >> shift;
    if (d == '0) d = 32'd1;
    return sat_sub(t, d);
  endfunction

endpackage

// File: rtl/lif_stdp_core_synapse.sv
// One plastic synapse: weight register, pre-synaptic trace and
// write/LTP/LTD arbitration. Trace and learning exist only with LIF_STDP_EN.
module stdp_synapse
  import lif_stdp_pkg::*;
#(
  parameter int unsigned W_WIDTH     = W_WIDTH_DEF,
  parameter int unsigned TRACE_WIDTH = TRACE_WIDTH_DEF,
  parameter int unsigned TRACE_SHIFT = 2,
  parameter int unsigned STDP_SHIFT  = 3,
  parameter int unsigned W_INIT      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick,
  input  logic                   spike,
  input  logic                   fire,
  input  logic [TRACE_WIDTH-1:0] post_tr,
  input  logic                   learn_en,
  input  logic                   wr,
  input  logic [W_WIDTH-1:0]     wr_data,
  output logic [W_WIDTH-1:0]     weight
);

  localparam logic [W_WIDTH-1:0] W_MAX = '1;

`ifdef LIF_STDP_EN
  logic [TRACE_WIDTH-1:0] pre_tr;
  logic [TRACE_WIDTH-1:0] pre_next;
  logic [W_WIDTH-1:0]     ltp_w;
  logic [W_WIDTH-1:0]     ltd_w;

  // Next pre trace and the two candidate learned weights
  always_comb begin
    pre_next = spike ? '1 : TRACE_WIDTH'(trace_decay(32'(pre_tr), TRACE_SHIFT));
    ltp_w    = W_WIDTH'(sat_add(32'(weight), 32'(pre_next >> STDP_SHIFT), 32'(W_MAX)));
    ltd_w    = W_WIDTH'(sat_sub(32'(weight), 32'(post_tr >> STDP_SHIFT)));
  end

  // Pre trace advances once per tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pre_tr <= '0;
    else if (tick) pre_tr <= pre_next;
  end

  // Host write has priority; otherwise LTP on fire, LTD on an unanswered input spike
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight <= W_WIDTH'(W_INIT);
    end else if (wr) begin
      weight <= wr_data;
    end else if (tick && learn_en) begin
      if (fire)       weight <= ltp_w;
      else if (spike) weight <= ltd_w;
    end
  end
`else
  logic unused_learning;
  assign unused_learning = ^{tick, spike, fire, post_tr, learn_en, W_MAX};

  // Without plasticity the weight changes only through the write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  weight <= W_WIDTH'(W_INIT);
    else if (wr) weight <= wr_data;
  end
`endif

endmodule

// File: rtl/lif_stdp_core.sv
// Leaky integrate-and-fire neuron with N_IN weighted synapses, refractory
// period and optional STDP learning (enabled by defining LIF_STDP_EN).
module lif_stdp_core
  import lif_stdp_pkg::*;
#(
  parameter logic [23:0] MAX_COUNT   = 24'd10_000_000,
  parameter int unsigned N_IN        = 8,
  parameter int unsigned W_WIDTH     = W_WIDTH_DEF,
  parameter int unsigned V_WIDTH     = 12,
  parameter int unsigned TRACE_WIDTH = TRACE_WIDTH_DEF,
  parameter int unsigned LEAK_SHIFT  = 3,
  parameter int unsigned TRACE_SHIFT = 2,
  parameter int unsigned STDP_SHIFT  = 3,
  parameter int unsigned REFRAC      = 4,
  parameter int unsigned W_INIT      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_IN-1:0]          spike_in,
  input  logic [V_WIDTH-1:0]       thresh,
  input  logic                     learn_en,
  input  logic                     wr_en,
  input  logic [$clog2(N_IN)-1:0]  wr_addr,
  input  logic [W_WIDTH-1:0]       wr_data,
  input  logic [$clog2(N_IN)-1:0]  rd_addr,
  output logic [W_WIDTH-1:0]       rd_data,
  output logic                     spike_out,
  output logic [V_WIDTH-1:0]       membrane,
  output logic                     tick_out
);

  localparam int unsigned AW = $clog2(N_IN);
  localparam int unsigned SW = V_WIDTH + AW + 1;
  localparam int unsigned RW = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);
  localparam logic [V_WIDTH-1:0] V_MAX = '1;

  logic [23:0]            count;
  logic                   tick;
  logic [W_WIDTH-1:0]     w [N_IN];
  logic [N_IN-1:0]        wr_sel;
  logic [TRACE_WIDTH-1:0] post_tr;
  logic [RW-1:0]          refrac_cnt;
  logic [V_WIDTH-1:0]     v;
  logic [SW-1:0]          syn_sum;
  logic [SW-1:0]          v_next;
  logic [V_WIDTH-1:0]     v_sat;
  logic                   fire;

  assign tick     = (count == MAX_COUNT - 24'd1);
  assign tick_out = tick;
  assign membrane = v;

  // Timestep prescaler, wraps after MAX_COUNT cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    count <= '0;
    else if (tick) count <= '0;
    else           count <= count + 24'd1;
  end

  // Decode the write strobe to one synapse
  always_comb begin
    wr_sel = '0;
    for (int unsigned i = 0; i < N_IN; i++)
      wr_sel[i] = wr_en && (wr_addr == AW'(i));
  end

  for (genvar g = 0; g < N_IN; g++) begin : g_syn
    stdp_synapse #(
      .W_WIDTH     (W_WIDTH),
      .TRACE_WIDTH (TRACE_WIDTH),
      .TRACE_SHIFT (TRACE_SHIFT),
      .STDP_SHIFT  (STDP_SHIFT),
      .W_INIT      (W_INIT)
    ) u_syn (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .spike    (spike_in[g]),
      .fire     (fire),
      .post_tr  (post_tr),
      .learn_en (learn_en),
      .wr       (wr_sel[g]),
      .wr_data  (wr_data),
      .weight   (w[g])
    );
  end

  // Weighted input sum, leak, saturation and threshold test
  always_comb begin
    syn_sum = '0;
    for (int unsigned i = 0; i < N_IN; i++)
      if (spike_in[i]) syn_sum = syn_sum + SW'(w[i]);
    v_next = SW'(v) - SW'(v >> LEAK_SHIFT) + syn_sum;
    v_sat  = (v_next > SW'(V_MAX)) ? V_MAX : v_next[V_WIDTH-1:0];
    fire   = tick && (refrac_cnt == '0) && (v_sat >= thresh);
  end

  // Membrane and refractory counter advance on ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v          <= '0;
      refrac_cnt <= '0;
    end else if (tick) begin
      if (refrac_cnt != '0) begin
        v          <= '0;
        refrac_cnt <= refrac_cnt - RW'(1);
      end else if (fire) begin
        v          <= '0;
        refrac_cnt <= RW'(REFRAC);
      end else begin
        v <= v_sat;
      end
    end
  end

  // Output spike is the registered fire decision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) spike_out <= 1'b0;
    else        spike_out <= fire;
  end

`ifdef LIF_STDP_EN
  // Post-synaptic trace: reload on fire, decay otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      post_tr <= '0;
    else if (tick)
      post_tr <= fire ? '1 : TRACE_WIDTH'(trace_decay(32'(post_tr), TRACE_SHIFT));
  end
`else
  assign post_tr = '0;
`endif

  // Registered weight readback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= w[rd_addr];
  end

endmodule

// File: tb/tb_lif_stdp_core.sv
// Scoreboard bench for lif_stdp_core with a 4-cycle timestep.
module tb_lif_stdp_core;
  import lif_stdp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  spike_in;
  logic [11:0] thresh;
  logic        learn_en;
  logic        wr_en;
  logic [2:0]  wr_addr;
  weight_t     wr_data;
  logic [2:0]  rd_addr;
  weight_t     rd_data;
  logic        spike_out;
  logic [11:0] membrane;
  logic        tick_out;

  always #5 clk = ~clk;

  lif_stdp_core #(.MAX_COUNT(24'd4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spike_in  (spike_in),
    .thresh    (thresh),
    .learn_en  (learn_en),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .spike_out (spike_out),
    .membrane  (membrane),
    .tick_out  (tick_out)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { string name; int unsigned v; bit spk; } tick_exp_t;
  typedef struct { string name; int unsigned d; } rd_exp_t;
  tick_exp_t tq[$];
  rd_exp_t   rq[$];
  logic      tick_seen;
  bit        low_next = 1'b0;

`ifdef LIF_STDP_EN
  localparam int unsigned EXP_W0_LEARN = 107;
  localparam int unsigned EXP_W1_LEARN = 9;
`else
  localparam int unsigned EXP_W0_LEARN = 100;
  localparam int unsigned EXP_W1_LEARN = 16;
`endif

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) tick_seen <= 1'b0;
    else        tick_seen <= tick_out;

  // Monitor: compare whenever the DUT presents a post-tick result or readback
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (low_next) begin
        cmp("spike_width", 32'(spike_out), 32'd0);
        low_next = 1'b0;
      end
      if (tick_seen && tq.size() > 0) begin
        tick_exp_t e;
        e = tq.pop_front();
        cmp({e.name, "_membrane"}, 32'(membrane), e.v);
        cmp({e.name, "_spike"}, 32'(spike_out), 32'(e.spk));
        if (e.spk) low_next = 1'b1;
      end
      if (rq.size() > 0) begin
        rd_exp_t r;
        r = rq.pop_front();
        cmp(r.name, 32'(rd_data), r.d);
      end
    end
  end

  task automatic wait_tick();
    bit got = 1'b0;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      if (tick_out === 1'b1) got = 1'b1;
    end
    if (!got) cmp("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic tick_step(input logic [7:0] sp, input int unsigned v, input bit spk, input string name);
    tick_exp_t e;
    wait_tick();
    spike_in = sp;
    e.name = name; e.v = v; e.spk = spk;
    tq.push_back(e);
  endtask

  task automatic write_w(input logic [2:0] a, input weight_t d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic read_chk(input logic [2:0] a, input int unsigned d, input string name);
    rd_exp_t r;
    @(negedge clk);
    rd_addr = a;
    @(posedge clk);
    #1;
    r.name = name; r.d = d;
    rq.push_back(r);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (tq.size() > 0 || rq.size() > 0); i++) @(negedge clk);
    @(negedge clk);
    cmp("drain_pending", 32'(tq.size() + rq.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; spike_in = '0; learn_en = 1'b0; wr_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int unsigned b_v [8]   = '{64, 0, 0, 0, 0, 0, 64, 0};
  bit          b_spk [8] = '{0, 1, 0, 0, 0, 0, 0, 1};
  int unsigned c_v [4]   = '{80, 70, 62, 55};

  initial begin
    rst_n = 1'b0; spike_in = '0; thresh = 12'd4095; learn_en = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    #23 rst_n = 1'b1;

    // Reset: build up nonzero state, then reset asynchronously inside a tick cycle
    read_chk(3'd3, 16, "pre_rst_w3");
    tick_step(8'h0F, 64, 1'b0, "pre_rst");
    drain();
    wait_tick();
    #1 rst_n = 1'b0;
    #1;
    cmp("rst_membrane", 32'(membrane), 32'd0);
    cmp("rst_spike_out", 32'(spike_out), 32'd0);
    cmp("rst_tick_out", 32'(tick_out), 32'd0);
    cmp("rst_rd_data", 32'(rd_data), 32'd0);
    spike_in = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) read_chk(3'(a), 16, $sformatf("rst_w%0d", a));
    drain();

    // Integration, fire and refractory
    do_reset();
    thresh = 12'd100;
    for (int t = 0; t < 8; t++)
      tick_step(8'h0F, b_v[t], b_spk[t], $sformatf("int_t%0d", t + 1));
    drain();

    // Leak after a single input pulse
    do_reset();
    thresh = 12'd4095;
    write_w(3'd0, 8'd80);
    read_chk(3'd0, 80, "leak_w0");
    for (int t = 0; t < 4; t++)
      tick_step((t == 0) ? 8'h01 : 8'h00, c_v[t], 1'b0, $sformatf("leak_t%0d", t + 1));
    drain();

    // Learning: LTP on fire, LTD during refractory, saturation at full scale
    do_reset();
    learn_en = 1'b1;
    thresh = 12'd90;
    write_w(3'd0, 8'd100);
    tick_step(8'h01, 0, 1'b1, "stdp_fire");
    tick_step(8'h02, 0, 1'b0, "stdp_ltd");
    tick_step(8'h00, 0, 1'b0, "stdp_quiet");
    drain();
    read_chk(3'd0, EXP_W0_LEARN, "stdp_w0");
    read_chk(3'd1, EXP_W1_LEARN, "stdp_w1");
    write_w(3'd0, 8'd255);
    repeat (6) wait_tick();
    tick_step(8'h01, 0, 1'b1, "stdp_refire");
    tick_step(8'h00, 0, 1'b0, "stdp_after");
    drain();
    read_chk(3'd0, 255, "stdp_w0_sat");
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
